// File: rtl/axi_burst_ram_if.sv
// AXI4-style burst RAM slave bus: AW/W/B write channels and AR/R read channels.
// The master modport drives requests; the slave modport is used by the RAM.
interface axi_burst_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]   s_axi_awid;
  logic [ADDR_WIDTH-1:0] s_axi_awaddr;
  logic [7:0]            s_axi_awlen;
  logic                  s_axi_awvalid;
  logic                  s_axi_awready;

  logic [DATA_WIDTH-1:0] s_axi_wdata;
  logic [STRB_WIDTH-1:0] s_axi_wstrb;
  logic                  s_axi_wlast;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;

  logic [ID_WIDTH-1:0]   s_axi_bid;
  logic [1:0]            s_axi_bresp;
  logic                  s_axi_bvalid;
  logic                  s_axi_bready;

  logic [ID_WIDTH-1:0]   s_axi_arid;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic [7:0]            s_axi_arlen;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;

  logic [ID_WIDTH-1:0]   s_axi_rid;
  logic [DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rlast;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );
endinterface

// File: rtl/axi_burst_ram.sv
// Byte-strobed RAM behind an AXI INCR-burst slave with independent read and
// write engines; reads are registered (one cycle latency) and read-first.
module axi_burst_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  axi_burst_ram_if.slave bus
);
  localparam int LSB     = $clog2(STRB_WIDTH);
  localparam int WORD_AW = ADDR_WIDTH - LSB;
  localparam int DEPTH   = 1 << WORD_AW;

  typedef logic [WORD_AW-1:0] waddr_t;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_BURST} rd_state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Holds the address-channel readies low until the first edge after reset.
  logic run_q;

  wr_state_e           wr_state_q, wr_state_d;
  waddr_t              wr_addr_q,  wr_addr_d;
  logic [7:0]          wr_cnt_q,   wr_cnt_d;
  logic [ID_WIDTH-1:0] bid_q,      bid_d;
  logic                wr_en;

  rd_state_e             rd_state_q, rd_state_d;
  waddr_t                rd_addr_q,  rd_addr_d;
  logic [7:0]            rd_cnt_q,   rd_cnt_d;
  logic [ID_WIDTH-1:0]   rid_q,      rid_d;
  logic                  rlast_q,    rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rd_load;
  waddr_t                rd_fetch;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic unused_ok;

  assign bus.s_axi_awready = run_q && (wr_state_q == WR_IDLE);
  assign bus.s_axi_wready  = (wr_state_q == WR_DATA);
  assign bus.s_axi_bvalid  = (wr_state_q == WR_RESP);
  assign bus.s_axi_bid     = bid_q;
  assign bus.s_axi_bresp   = 2'b00;

  assign bus.s_axi_arready = run_q && (rd_state_q == RD_IDLE);
  assign bus.s_axi_rvalid  = (rd_state_q == RD_BURST);
  assign bus.s_axi_rid     = rid_q;
  assign bus.s_axi_rdata   = rdata_q;
  assign bus.s_axi_rresp   = 2'b00;
  assign bus.s_axi_rlast   = rlast_q;

  assign aw_hs = bus.s_axi_awvalid && bus.s_axi_awready;
  assign w_hs  = bus.s_axi_wvalid  && bus.s_axi_wready;
  assign b_hs  = bus.s_axi_bvalid  && bus.s_axi_bready;
  assign ar_hs = bus.s_axi_arvalid && bus.s_axi_arready;
  assign r_hs  = bus.s_axi_rvalid  && bus.s_axi_rready;

  // Burst length is tracked by beat count alone, so wlast and the sub-word
  // address bits carry no information for this slave.
  assign unused_ok = &{1'b0, bus.s_axi_wlast, bus.s_axi_awaddr, bus.s_axi_araddr};

  // ---------------------------------------------------------------- write path
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which is what keeps combinational blocks from inferring latches.
    wr_state_d = wr_state_q;
    wr_addr_d  = wr_addr_q;
    wr_cnt_d   = wr_cnt_q;
    bid_d      = bid_q;
    wr_en      = 1'b0;
    unique case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          wr_addr_d  = bus.s_axi_awaddr[ADDR_WIDTH-1:LSB];
          wr_cnt_d   = bus.s_axi_awlen;
          bid_d      = bus.s_axi_awid;
          wr_state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (w_hs) begin
          wr_en     = 1'b1;
          wr_addr_d = wr_addr_q + waddr_t'(1);
          if (wr_cnt_q == 8'd0) wr_state_d = WR_RESP;
          else                  wr_cnt_d   = wr_cnt_q - 8'd1;
        end
      end
      WR_RESP: begin
        if (b_hs) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- read path
  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    rd_cnt_d   = rd_cnt_q;
    rid_d      = rid_q;
    rlast_d    = rlast_q;
    rd_load    = 1'b0;
    rd_fetch   = rd_addr_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_fetch   = bus.s_axi_araddr[ADDR_WIDTH-1:LSB];
          rd_addr_d  = rd_fetch;
          rd_cnt_d   = bus.s_axi_arlen;
          rid_d      = bus.s_axi_arid;
          rlast_d    = (bus.s_axi_arlen == 8'd0);
          rd_load    = 1'b1;
          rd_state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        if (r_hs) begin
          if (rlast_q) begin
            rlast_d    = 1'b0;
            rd_state_d = RD_IDLE;
          end else begin
            // Prefetch the next word on the accepting edge so beats stream
            // back-to-back without a bubble.
            rd_fetch  = rd_addr_q + waddr_t'(1);
            rd_addr_d = rd_fetch;
            rd_cnt_d  = rd_cnt_q - 8'd1;
            rlast_d   = (rd_cnt_q == 8'd1);
            rd_load   = 1'b1;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement or process order.
      run_q      <= 1'b0;
      wr_state_q <= WR_IDLE;
      wr_addr_q  <= '0;
      wr_cnt_q   <= '0;
      bid_q      <= '0;
      rd_state_q <= RD_IDLE;
      rd_addr_q  <= '0;
      rd_cnt_q   <= '0;
      rid_q      <= '0;
      rlast_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      run_q      <= 1'b1;
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_cnt_q   <= wr_cnt_d;
      bid_q      <= bid_d;
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      rid_q      <= rid_d;
      rlast_q    <= rlast_d;
      // Sampled on the same edge as any write, so a colliding read sees old data.
      if (rd_load) rdata_q <= mem_q[rd_fetch];
    end
  end

  // NOTE: the storage array has no reset; clearing it would forbid RAM
  // inference and its contents are defined only by writes anyway.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (bus.s_axi_wstrb[b]) mem_q[wr_addr_q][8*b +: 8] <= bus.s_axi_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_ram.sv
// Randomized bench for axi_burst_ram against a byte-array model of the RAM;
// covers reset, bursts, strobes, stalls, address wrap, read-first and reset abort.
module tb_axi_burst_ram;
  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int SW    = DW / 8;
  localparam int IW    = 8;
  localparam int WORDS = (1 << AW) / SW;
  localparam int TMO   = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  axi_burst_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) axi ();

  axi_burst_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (axi.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]    model [1 << AW];
  logic [DW-1:0] wbeat_data [256];
  logic [SW-1:0] wbeat_strb [256];
  int            wlast_at;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int word_of(input logic [AW-1:0] addr, input int beat);
    return (int'(addr) / SW + beat) % WORDS;
  endfunction

  function automatic logic [DW-1:0] model_word(input int w);
    logic [DW-1:0] v;
    for (int b = 0; b < SW; b++) v[8*b +: 8] = model[w*SW + b];
    return v;
  endfunction

  task automatic model_write(input int w, input logic [DW-1:0] d, input logic [SW-1:0] s);
    for (int b = 0; b < SW; b++) if (s[b]) model[w*SW + b] = d[8*b +: 8];
  endtask

  // All channel tasks start and end on a falling edge.
  task automatic send_aw(input logic [AW-1:0] addr, input int len, input logic [IW-1:0] id);
    int n = 0;
    axi.s_axi_awid = id; axi.s_axi_awaddr = addr; axi.s_axi_awlen = len[7:0];
    axi.s_axi_awvalid = 1'b1;
    while (!axi.s_axi_awready && n < TMO) begin @(negedge clk); n++; end
    check("aw_accepted", n < TMO, 1);
    @(negedge clk);
    axi.s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input int beat, input int w, input bit gaps);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin axi.s_axi_wvalid = 1'b0; @(negedge clk); end
    axi.s_axi_wdata = wbeat_data[beat]; axi.s_axi_wstrb = wbeat_strb[beat];
    axi.s_axi_wlast = (beat == wlast_at); axi.s_axi_wvalid = 1'b1;
    while (!axi.s_axi_wready && n < TMO) begin @(negedge clk); n++; end
    check("w_accepted", n < TMO, 1);
    @(negedge clk);
    model_write(w, wbeat_data[beat], wbeat_strb[beat]);
  endtask

  task automatic recv_b(input logic [IW-1:0] id, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 3)) begin
      check("bvalid_hold", axi.s_axi_bvalid, 1);
      @(negedge clk);
    end
    check("bvalid", axi.s_axi_bvalid, 1);
    check("bid", axi.s_axi_bid, id);
    check("bresp", axi.s_axi_bresp, 0);
    axi.s_axi_bready = 1'b1;
    @(negedge clk);
    axi.s_axi_bready = 1'b0;
    check("bvalid_clear", axi.s_axi_bvalid, 0);
    check("awready_back", axi.s_axi_awready, 1);
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input int len, input logic [IW-1:0] id,
                           input bit gaps);
    @(negedge clk);
    send_aw(addr, len, id);
    for (int i = 0; i <= len; i++) send_w(i, word_of(addr, i), gaps);
    axi.s_axi_wvalid = 1'b0; axi.s_axi_wlast = 1'b0;
    check("bvalid_after_last_w", axi.s_axi_bvalid, 1);
    check("wready_after_last_w", axi.s_axi_wready, 0);
    recv_b(id, gaps);
    wlast_at = -1;
  endtask

  // mode 0: random rready, 1: repeating 1,0,0,1 pattern, 2: always ready.
  task automatic axi_read(input logic [AW-1:0] addr, input int len, input logic [IW-1:0] id,
                          input int mode);
    int n = 0;
    int i = 0;
    int k = 0;
    bit rr;
    logic [3:0] pat = 4'b1001;
    @(negedge clk);
    axi.s_axi_arid = id; axi.s_axi_araddr = addr; axi.s_axi_arlen = len[7:0];
    axi.s_axi_arvalid = 1'b1;
    while (!axi.s_axi_arready && n < TMO) begin @(negedge clk); n++; end
    check("ar_accepted", n < TMO, 1);
    @(negedge clk);
    axi.s_axi_arvalid = 1'b0;
    n = 0;
    while (i <= len && n < TMO) begin
      check("rvalid", axi.s_axi_rvalid, 1);
      check("rdata", axi.s_axi_rdata, model_word(word_of(addr, i)));
      check("rlast", axi.s_axi_rlast, i == len);
      check("rid", axi.s_axi_rid, id);
      check("rresp", axi.s_axi_rresp, 0);
      case (mode)
        0:       rr = 1'($urandom_range(0, 1));
        1:       rr = pat[k % 4];
        default: rr = 1'b1;
      endcase
      axi.s_axi_rready = rr;
      @(negedge clk);
      if (rr) i++;
      k++; n++;
    end
    axi.s_axi_rready = 1'b0;
    check("r_beats", i, len + 1);
    check("rvalid_end", axi.s_axi_rvalid, 0);
    check("arready_end", axi.s_axi_arready, 1);
  endtask

  // Write and read hit the same word on the same edge; the read must see old data.
  task automatic read_first_check(input logic [AW-1:0] addr);
    logic [DW-1:0] old_w, new_w;
    int w = word_of(addr, 0);
    old_w = model_word(w);
    new_w = ~old_w ^ DW'($urandom);
    @(negedge clk);
    send_aw(addr, 0, 8'h5A);
    axi.s_axi_wdata = new_w; axi.s_axi_wstrb = '1; axi.s_axi_wlast = 1'b1;
    axi.s_axi_wvalid = 1'b1;
    axi.s_axi_arid = 8'hA5; axi.s_axi_araddr = addr; axi.s_axi_arlen = 8'd0;
    axi.s_axi_arvalid = 1'b1;
    check("rf_wready", axi.s_axi_wready, 1);
    check("rf_arready", axi.s_axi_arready, 1);
    @(negedge clk);
    axi.s_axi_wvalid = 1'b0; axi.s_axi_arvalid = 1'b0; axi.s_axi_wlast = 1'b0;
    check("rf_rvalid", axi.s_axi_rvalid, 1);
    check("rf_rdata_old", axi.s_axi_rdata, old_w);
    check("rf_rlast", axi.s_axi_rlast, 1);
    axi.s_axi_rready = 1'b1;
    @(negedge clk);
    axi.s_axi_rready = 1'b0;
    check("rf_rvalid_end", axi.s_axi_rvalid, 0);
    model_write(w, new_w, '1);
    recv_b(8'h5A, 1'b0);
    axi_read(addr, 0, 8'h11, 2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, axi.s_axi_awready, 0);
    check({tag, "_wready"},  axi.s_axi_wready, 0);
    check({tag, "_bvalid"},  axi.s_axi_bvalid, 0);
    check({tag, "_arready"}, axi.s_axi_arready, 0);
    check({tag, "_rvalid"},  axi.s_axi_rvalid, 0);
    check({tag, "_rlast"},   axi.s_axi_rlast, 0);
    check({tag, "_bid"},     axi.s_axi_bid, 0);
    check({tag, "_rid"},     axi.s_axi_rid, 0);
    check({tag, "_rdata"},   axi.s_axi_rdata, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("awready_before_edge", axi.s_axi_awready, 0);
    @(posedge clk);
    #1;
    check("awready_first_edge", axi.s_axi_awready, 1);
    check("arready_first_edge", axi.s_axi_arready, 1);
    @(negedge clk);
  endtask

  // Reset lands while beat 2 of a 4-beat write is offered; only beats 0-1 persist.
  task automatic reset_mid_write(input logic [AW-1:0] addr);
    @(negedge clk);
    send_aw(addr, 3, 8'h33);
    send_w(0, word_of(addr, 0), 1'b0);
    send_w(1, word_of(addr, 1), 1'b0);
    axi.s_axi_wdata = wbeat_data[2]; axi.s_axi_wstrb = '1; axi.s_axi_wvalid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_wready", axi.s_axi_wready, 0);
    check("rst_bvalid", axi.s_axi_bvalid, 0);
    check_reset_outputs("rst_mid");
    axi.s_axi_wvalid = 1'b0;
    repeat (2) @(negedge clk);
    release_reset();
    repeat (3) begin
      check("no_b_after_abort", axi.s_axi_bvalid, 0);
      check("no_wready_after_abort", axi.s_axi_wready, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    int len;
    logic [AW-1:0] ra;
    int rlen;

    wlast_at = -1;
    axi.s_axi_awid = '0; axi.s_axi_awaddr = '0; axi.s_axi_awlen = '0; axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wdata = '0; axi.s_axi_wstrb = '0; axi.s_axi_wlast = 1'b0; axi.s_axi_wvalid = 1'b0;
    axi.s_axi_bready = 1'b0;
    axi.s_axi_arid = '0; axi.s_axi_araddr = '0; axi.s_axi_arlen = '0; axi.s_axi_arvalid = 1'b0;
    axi.s_axi_rready = 1'b0;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    release_reset();

    // Give every word a known value so any later read has a defined expectation.
    for (int blk = 0; blk < WORDS / 256; blk++) begin
      for (int i = 0; i < 256; i++) begin wbeat_data[i] = $urandom; wbeat_strb[i] = '1; end
      axi_write(AW'(blk * 256 * SW), 255, IW'(blk), 1'b0);
    end

    wbeat_data[0] = 32'hDEADBEEF; wbeat_strb[0] = 4'hF;
    axi_write(12'h010, 0, 8'h01, 1'b0);
    axi_read(12'h010, 0, 8'h02, 2);
    check("single_word_value", model_word(4), 32'hDEADBEEF);

    for (int i = 0; i < 4; i++) begin wbeat_data[i] = DW'(i + 1); wbeat_strb[i] = '1; end
    wlast_at = 2;
    axi_write(12'h100, 3, 8'h03, 1'b0);
    axi_read(12'h100, 3, 8'h04, 2);
    axi_read(12'h100, 3, 8'h05, 1);

    wbeat_data[0] = 32'hFFFFFFFF; wbeat_strb[0] = 4'hF;
    axi_write(12'h020, 0, 8'h06, 1'b0);
    wbeat_data[0] = 32'h00000000; wbeat_strb[0] = 4'h5;
    axi_write(12'h020, 0, 8'h07, 1'b0);
    axi_read(12'h020, 0, 8'h08, 2);
    check("strobe_merge_value", model_word(8), 32'hFF00FF00);

    wbeat_data[0] = 32'hA5A5_0001; wbeat_data[1] = 32'h5A5A_0002;
    wbeat_strb[0] = '1; wbeat_strb[1] = '1;
    axi_write(12'hFFC, 1, 8'h09, 1'b0);
    axi_read(12'hFFC, 1, 8'h0A, 0);
    axi_read(12'h000, 0, 8'h0B, 2);
    check("wrap_value", model_word(0), 32'h5A5A_0002);

    read_first_check(12'h344);

    for (int i = 0; i < 4; i++) wbeat_data[i] = $urandom;
    for (int i = 0; i < 4; i++) wbeat_strb[i] = '1;
    reset_mid_write(12'h200);
    axi_read(12'h200, 3, 8'h0C, 2);

    for (int it = 0; it < 12; it++) begin
      a   = AW'($urandom);
      len = $urandom_range(0, 31);
      for (int i = 0; i <= len; i++) begin wbeat_data[i] = $urandom; wbeat_strb[i] = SW'($urandom); end
      axi_write(a, len, IW'($urandom), 1'b1);
      axi_read(a, len, IW'($urandom), 0);
    end

    // Concurrent traffic on disjoint halves of the array.
    for (int it = 0; it < 6; it++) begin
      len  = $urandom_range(0, 31);
      a    = AW'($urandom_range(0, WORDS / 2 - 1 - len) * SW);
      rlen = $urandom_range(0, 31);
      ra   = AW'($urandom_range(WORDS / 2, WORDS - 1 - rlen) * SW);
      for (int i = 0; i <= len; i++) begin wbeat_data[i] = $urandom; wbeat_strb[i] = SW'($urandom); end
      fork
        axi_write(a, len, IW'(8'h40 + it), 1'b1);
        axi_read(ra, rlen, IW'(8'h80 + it), 0);
      join
      axi_read(a, len, IW'(8'hC0 + it), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_burst_ram.md
AXI_BURST_RAM -- requirements
Module: axi_burst_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, byte-address width; memory depth = 2^ADDR_WIDTH bytes.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, number of byte strobes.
REQ-004 SHALL have parameter ID_WIDTH, default 8, transaction ID width.
REQ-005 SHALL have ports; one clock, reset asynchronous and active-low:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
s_axi_awid  in  ID_WIDTH  write ID
s_axi_awaddr  in  ADDR_WIDTH  write start byte address
s_axi_awlen  in  8  write beats minus one
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  STRB_WIDTH  byte enables
s_axi_wlast  in  1  last write beat (informational)
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  ID_WIDTH  response ID
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_arid  in  ID_WIDTH  read ID
s_axi_araddr  in  ADDR_WIDTH  read start byte address
s_axi_arlen  in  8  read beats minus one
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  ID_WIDTH  read ID
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  last read beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready

Function
REQ-006 SHALL implement INCR bursts of full-width beats only; byte address increments by STRB_WIDTH per beat, low log2(STRB_WIDTH) address bits ignored, address wraps modulo 2^ADDR_WIDTH.
REQ-007 Write FSM SHALL have states IDLE, DATA, RESP; awready=1 only in IDLE, wready=1 only in DATA, bvalid=1 only in RESP.
REQ-008 IDLE->DATA on AW handshake, capturing awid, word address and awlen as beat counter; DATA->RESP on the W handshake of beat awlen (beat count governs; wlast ignored); RESP->IDLE on B handshake.
REQ-009 Each W handshake SHALL write only bytes with wstrb=1 at the current word, effective on the same clock edge.
REQ-010 bresp and rresp SHALL always be 2'b00 (OKAY); bid equals captured awid.
REQ-011 Read FSM SHALL have states IDLE, BURST; arready=1 only in IDLE; AR handshake enters BURST with rvalid=1, rid=arid, first beat data on the next cycle (1-cycle latency).
REQ-012 In BURST, rdata/rlast/rid SHALL hold stable while rvalid=1 and rready=0; on R handshake the next word is presented the next cycle with no bubble.
REQ-013 rlast SHALL be 1 exactly on beat arlen; R handshake of that beat returns to IDLE with rvalid=0, arready=1 next cycle.
REQ-014 Read and write paths SHALL operate concurrently and independently; same-word read and write in one cycle returns the old data (read-first).

Reset
REQ-015 While rst_n=0: awready, wready, bvalid, arready, rvalid, rlast=0; bid, rid, rdata=0; both FSMs IDLE; memory contents not reset.
REQ-016 awready and arready SHALL assert on the first rising clk edge after rst_n deasserts; reset mid-burst abandons the burst with no further beats or response.

Verification
REQ-017 Write awaddr=0x010, awlen=0, wdata=0xDEADBEEF, wstrb=0xF -> bvalid next cycle after W, bresp=00; read araddr=0x010 -> rdata=0xDEADBEEF, rlast=1.
REQ-018 Write burst awlen=3 at 0x100 data 1,2,3,4 with wlast only on beat 2 -> exactly 4 beats accepted, one B; read back 0x100 len 3 -> 1,2,3,4, rlast on beat 4 only.
REQ-019 Read len 3 with rready toggling 1,0,0,1... -> rdata/rlast stable across stalls, beats in order, no beat dropped or duplicated.
REQ-020 Write 0xFFFFFFFF then 0x00000000 with wstrb=0x5 at 0x020 -> read 0xFF00FF00.
REQ-021 Burst len 1 at 0xFFC (ADDR_WIDTH=12) -> second beat at 0x000; read back confirms wrap.
REQ-022 Assert rst_n=0 during beat 2 of a 4-beat write -> wready, bvalid=0 immediately, no B issued, awready=1 one edge after rst_n rises.
